// File: rtl/bs_lfsr.sv
// Free-running Fibonacci LFSR pattern source with serial bit, pattern index and period tick.
// Optional macro BS_LFSR_LOCKUP_RECOVERY_EN adds recovery from the all-zero lock-up state.
module bs_lfsr #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(5'b10100),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(5'b00001)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             serial_out,
    output logic [WIDTH-1:0] pattern_idx,
    output logic             period_tick
);

`ifdef BS_LFSR_LOCKUP_RECOVERY_EN
    // A zero seed would lock the register up, so fall back to 1.
    localparam logic [WIDTH-1:0] EFF_SEED = (SEED != '0) ? SEED : WIDTH'(1);
`else
    localparam logic [WIDTH-1:0] EFF_SEED = SEED;
`endif

    logic             fb;
    logic [WIDTH-1:0] next_state;
    logic             wrap;

    always_comb begin
        fb         = ^(lfsr_out & TAPS);
        next_state = {lfsr_out[WIDTH-2:0], fb};
        wrap       = (next_state == EFF_SEED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_out    <= EFF_SEED;
            pattern_idx <= '0;
            period_tick <= 1'b0;
        end
`ifdef BS_LFSR_LOCKUP_RECOVERY_EN
        else if (lfsr_out == '0) begin
            lfsr_out    <= EFF_SEED;
            pattern_idx <= '0;
            period_tick <= 1'b0;
        end
`endif
        else begin
            lfsr_out    <= next_state;
            pattern_idx <= wrap ? '0 : pattern_idx + WIDTH'(1);
            period_tick <= wrap;
        end
    end

    assign serial_out = lfsr_out[WIDTH-1];

endmodule

// File: tb/tb_bs_lfsr.sv
// Randomized self-checking bench for bs_lfsr against a bit-stream recurrence model.
module tb_bs_lfsr;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] lfsrOut, patternIdx, zOut, zIdx;
    logic       serialOut, periodTick, zSerial, zTick;

    int vectors = 0;
    int miscompares = 0;

    // Model: the register holds the last five bits of the stream b[n] = b[n-5] ^ b[n-3].
    int win[$];
    int modelIdx;
    int modelTick;
    int seen[32];
    int distinct;

    bs_lfsr dut (
        .clk(clk), .rst(rst), .lfsr_out(lfsrOut), .serial_out(serialOut),
        .pattern_idx(patternIdx), .period_tick(periodTick)
    );

    bs_lfsr #(.WIDTH(5), .TAPS(5'b10100), .SEED(5'b00000)) dutZero (
        .clk(clk), .rst(rst), .lfsr_out(zOut), .serial_out(zSerial),
        .pattern_idx(zIdx), .period_tick(zTick)
    );

    always #5 clk = ~clk;

    function automatic int modelState();
        int s = 0;
        for (int j = 0; j < 5; j++) s = s | (win[j] << (4 - j));
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input bit doReset);
        if (doReset) begin
            win = '{0, 0, 0, 0, 1};
            modelIdx = 0;
            modelTick = 0;
        end else begin
            int nb = win[0] ^ win[2];
            win.push_back(nb);
            void'(win.pop_front());
            if (modelState() == 1) begin
                modelIdx = 0;
                modelTick = 1;
            end else begin
                modelIdx = (modelIdx + 1) % 32;
                modelTick = 0;
            end
        end
    endtask

    // One clock edge with the given reset level, then compare every output to the model.
    task automatic applyStimulus(input bit doReset);
        int ms;
        rst = doReset;
        @(posedge clk);
        #1;
        modelStep(doReset);
        ms = modelState();
        checkOutput("lfsr_out", 32'(lfsrOut), 32'(ms));
        checkOutput("pattern_idx", 32'(patternIdx), 32'(modelIdx));
        checkOutput("period_tick", 32'(periodTick), 32'(modelTick));
        checkOutput("serial_out", 32'(serialOut), 32'((ms >> 4) & 1));
`ifdef BS_LFSR_LOCKUP_RECOVERY_EN
        checkOutput("zero_seed_out", 32'(zOut), 32'(ms));
        checkOutput("zero_seed_idx", 32'(zIdx), 32'(modelIdx));
`else
        checkOutput("zero_seed_out", 32'(zOut), 32'd0);
`endif
    endtask

    initial begin
        int expSeq[8];
        int expSerial[5];
        expSeq    = '{5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101, 5'b01011, 5'b10110, 5'b01100};
        expSerial = '{0, 0, 0, 1, 0};

        applyStimulus(1'b1);
        checkOutput("reset_out", 32'(lfsrOut), 32'd1);
        checkOutput("reset_idx", 32'(patternIdx), 32'd0);
        checkOutput("reset_tick", 32'(periodTick), 32'd0);
        checkOutput("reset_serial", 32'(serialOut), 32'd0);

        for (int i = 0; i < 32; i++) seen[i] = 0;
        seen[lfsrOut] = 1;
        distinct = 1;
        for (int e = 1; e <= 32; e++) begin
            applyStimulus(1'b0);
            if (e <= 8) checkOutput("seq_literal", 32'(lfsrOut), 32'(expSeq[e-1]));
            if (e <= 5) checkOutput("serial_literal", 32'(serialOut), 32'(expSerial[e-1]));
            if (e <= 30) begin
                checkOutput("no_tick_mid", 32'(periodTick), 32'd0);
                checkOutput("idx_count", 32'(patternIdx), 32'(e));
            end
            if (e <= 31) begin
                if (lfsrOut != 5'd0 && seen[lfsrOut] == 0) distinct++;
                seen[lfsrOut] = 1;
            end
            if (e == 31) begin
                checkOutput("period_out", 32'(lfsrOut), 32'd1);
                checkOutput("period_tick", 32'(periodTick), 32'd1);
                checkOutput("period_idx", 32'(patternIdx), 32'd0);
                checkOutput("distinct_states", 32'(distinct), 32'd31);
            end
            if (e == 32) begin
                checkOutput("after_period_out", 32'(lfsrOut), 32'd2);
                checkOutput("after_period_tick", 32'(periodTick), 32'd0);
            end
        end

        // Mid-run reset after 12 shifts.
        for (int e = 0; e < 12; e++) applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("midreset_out", 32'(lfsrOut), 32'd1);
        checkOutput("midreset_idx", 32'(patternIdx), 32'd0);
        checkOutput("midreset_tick", 32'(periodTick), 32'd0);
        applyStimulus(1'b0);
        checkOutput("restart_out", 32'(lfsrOut), 32'd2);
        checkOutput("restart_idx", 32'(patternIdx), 32'd1);

        // Lock-up behaviour of the zero-seed instance over 40 free-running edges.
        for (int e = 0; e < 40; e++) applyStimulus(1'b0);

        // Randomized reset pulses over long free-running stretches.
        for (int e = 0; e < 600; e++) applyStimulus($urandom_range(0, 39) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
